// File: rtl/ex_muldiv_unit_if.sv
// EX-stage multiply/divide request/response bundle.
// MULDIV_MTHILO_EN adds the MTHI/MTLO write fields.
interface ex_muldiv_unit_if #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_OP   = 2
);
    logic               i_start;
    logic [NB_OP-1:0]   i_op;
    logic [NB_DATA-1:0] i_data_a;
    logic [NB_DATA-1:0] i_data_b;
    logic               i_hilo_read;
    logic               i_flush;
`ifdef MULDIV_MTHILO_EN
    logic               i_hi_we;
    logic               i_lo_we;
    logic [NB_DATA-1:0] i_wdata;
`endif
    logic               o_busy;
    logic               o_stall;
    logic               o_done;
    logic [NB_DATA-1:0] o_hi;
    logic [NB_DATA-1:0] o_lo;

    modport master (
`ifdef MULDIV_MTHILO_EN
        output i_hi_we, output i_lo_we, output i_wdata,
`endif
        output i_start, output i_op, output i_data_a, output i_data_b,
        output i_hilo_read, output i_flush,
        input  o_busy, input o_stall, input o_done, input o_hi, input o_lo
    );

    modport slave (
`ifdef MULDIV_MTHILO_EN
        input  i_hi_we, input i_lo_we, input i_wdata,
`endif
        input  i_start, input i_op, input i_data_a, input i_data_b,
        input  i_hilo_read, input i_flush,
        output o_busy, output o_stall, output o_done, output o_hi, output o_lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, one bit per cycle.
// Define MULDIV_MTHILO_EN to enable direct MTHI/MTLO writes.
module ex_muldiv_unit #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_OP   = 2,
    parameter int unsigned NB_CNT  = 6
) (
    input logic             i_clock,
    input logic             i_reset,
    ex_muldiv_unit_if.slave mdu
);
    localparam logic [NB_CNT-1:0] LastCnt = NB_CNT'(NB_DATA - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q;
    logic [NB_CNT-1:0]    cnt_q;
    logic                 is_div_q, neg_q, rem_neg_q, dz_q, done_q;
    logic [NB_DATA-1:0]   b_q, hi_q, lo_q;
    logic [2*NB_DATA-1:0] acc_q;

    logic                 op_signed, op_div, a_neg, b_neg;
    logic [NB_DATA-1:0]   a_abs, b_abs;
    logic [NB_DATA:0]     mul_sum, div_diff;
    logic [2*NB_DATA-1:0] mul_next, div_next, prod;
    logic [NB_DATA-1:0]   quo, rem, fix_hi, fix_lo;

    assign op_signed = ~mdu.i_op[0];
    assign op_div    = mdu.i_op[1];
    assign a_neg     = op_signed & mdu.i_data_a[NB_DATA-1];
    assign b_neg     = op_signed & mdu.i_data_b[NB_DATA-1];
    assign a_abs     = a_neg ? -mdu.i_data_a : mdu.i_data_a;
    assign b_abs     = b_neg ? -mdu.i_data_b : mdu.i_data_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[NB_DATA-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left; keep trial only if no borrow.
    assign div_diff = acc_q[2*NB_DATA-1:NB_DATA-1] - {1'b0, b_q};
    assign div_next = div_diff[NB_DATA] ? {acc_q[2*NB_DATA-2:0], 1'b0}
                                        : {div_diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};

    assign quo  = acc_q[NB_DATA-1:0];
    assign rem  = acc_q[2*NB_DATA-1:NB_DATA];
    assign prod = neg_q ? -acc_q : acc_q;

    always_comb begin
        fix_hi = prod[2*NB_DATA-1:NB_DATA];
        fix_lo = prod[NB_DATA-1:0];
        if (is_div_q) begin
            fix_lo = dz_q ? '1 : (neg_q ? -quo : quo);
            fix_hi = rem_neg_q ? -rem : rem;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
`ifdef MULDIV_MTHILO_EN
                    if (mdu.i_hi_we) hi_q <= mdu.i_wdata;
                    if (mdu.i_lo_we) lo_q <= mdu.i_wdata;
`endif
                    if (mdu.i_start && !mdu.i_flush) begin
                        state_q   <= StRun;
                        cnt_q     <= '0;
                        is_div_q  <= op_div;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= op_div & a_neg;
                        dz_q      <= op_div & (mdu.i_data_b == '0);
                        b_q       <= b_abs;
                        acc_q     <= {{NB_DATA{1'b0}}, a_abs};
                    end
                end
                StRun: begin
                    if (mdu.i_flush) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastCnt) state_q <= StFix;
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    if (!mdu.i_flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mdu.o_busy = (state_q != StIdle);
`ifdef MULDIV_MTHILO_EN
    assign mdu.o_stall = mdu.o_busy &
                         (mdu.i_start | mdu.i_hilo_read | mdu.i_hi_we | mdu.i_lo_we);
`else
    assign mdu.o_stall = mdu.o_busy & (mdu.i_start | mdu.i_hilo_read);
`endif
    assign mdu.o_done = done_q;
    assign mdu.o_hi   = hi_q;
    assign mdu.o_lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected {HI,LO} queued at issue, popped on o_done.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.NB_DATA(32), .NB_OP(2)) mdu_if ();

    ex_muldiv_unit #(.NB_DATA(32), .NB_OP(2), .NB_CNT(6)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .mdu     (mdu_if)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_hilo = '0;

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = 64'(sa / sb);
                r = 64'(sa % sb);
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Returns at the negedge of accept cycle 0.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push);
        @(negedge clk);
        mdu_if.i_start  = 1'b1;
        mdu_if.i_op     = op;
        mdu_if.i_data_a = a;
        mdu_if.i_data_b = b;
        if (push) sb_q.push_back(exp);
        @(negedge clk);
        mdu_if.i_start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit timeout);
        cyc = 0;
        timeout = 1'b0;
        while (mdu_if.o_done !== 1'b1) begin
            if (cyc >= 80) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        mdu_if.i_start = 1'b1;
        mdu_if.i_op = 2'b00;
        mdu_if.i_data_a = 32'h1;
        mdu_if.i_data_b = 32'h1;
        mdu_if.i_hilo_read = 1'b1;
        mdu_if.i_flush = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({mdu_if.o_busy, mdu_if.o_done, mdu_if.o_stall} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000",
                     {mdu_if.o_busy, mdu_if.o_done, mdu_if.o_stall});
        end
        checks++;
        if ({mdu_if.o_hi, mdu_if.o_lo} !== 64'h0) begin
            failures++;
            $display("FAIL reset_hilo: got %h expected 0", {mdu_if.o_hi, mdu_if.o_lo});
        end
        @(negedge clk);
        mdu_if.i_start = 1'b0;
        mdu_if.i_hilo_read = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_mult_timing();
        logic [63:0] exp, got;
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b1);
        for (int c = 0; c <= 33; c++) begin
            if (c >= 1) begin
                checks++;
                if (mdu_if.o_busy !== 1'(c <= 32)) begin
                    failures++;
                    $display("FAIL mult_busy c=%0d: got %b expected %b", c, mdu_if.o_busy,
                             1'(c <= 32));
                end
                checks++;
                if (mdu_if.o_done !== 1'(c == 33)) begin
                    failures++;
                    $display("FAIL mult_done c=%0d: got %b expected %b", c, mdu_if.o_done,
                             1'(c == 33));
                end
            end
            if (c == 16) begin
                checks++;
                if ({mdu_if.o_hi, mdu_if.o_lo} !== last_hilo) begin
                    failures++;
                    $display("FAIL mult_no_partial: got %h expected %h",
                             {mdu_if.o_hi, mdu_if.o_lo}, last_hilo);
                end
            end
            if (c < 33) @(negedge clk);
        end
        exp = sb_q.pop_front();
        got = {mdu_if.o_hi, mdu_if.o_lo};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mult_result: got %h expected %h", got, exp);
        end
        last_hilo = exp;
    endtask

    task automatic test_ops();
        logic [1:0]  ops[6]  = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [31:0] as[6]   = '{32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000,
                                 32'd5, 32'hFFFF_FFF7};
        logic [31:0] bs[6]   = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [63:0] exps[6] = '{{32'hFFFF_FFFE, 32'h0000_0001}, {32'd2, 32'd14},
                                 {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000},
                                 {32'd5, 32'hFFFF_FFFF}, {32'hFFFF_FFF7, 32'hFFFF_FFFF}};
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp, got;
        int          cyc;
        bit          to;
        for (int i = 0; i < 16; i++) begin
            if (i < 6) begin
                op = ops[i]; a = as[i]; b = bs[i]; exp = exps[i];
            end else begin
                op = 2'($urandom_range(0, 3));
                a = $urandom;
                b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                exp = model(op, a, b);
            end
            issue(op, a, b, exp, 1'b1);
            wait_done(cyc, to);
            checks++;
            if (to || cyc != 33) begin
                failures++;
                $display("FAIL op%0d_latency: got %0d expected 33 (timeout=%0b)", i, cyc, to);
            end
            exp = sb_q.pop_front();
            got = {mdu_if.o_hi, mdu_if.o_lo};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL op%0d_result op=%0d a=%h b=%h: got %h expected %h",
                         i, op, a, b, got, exp);
            end
            last_hilo = exp;
        end
    endtask

    task automatic test_stall_back_to_back();
        logic [63:0] exp, got;
        int          c, cyc;
        bit          to;
        @(negedge clk);
        mdu_if.i_start = 1'b1;
        mdu_if.i_op = 2'b11;
        mdu_if.i_data_a = 32'd100;
        mdu_if.i_data_b = 32'd7;
        sb_q.push_back({32'd2, 32'd14});
        @(negedge clk);
        mdu_if.i_op = 2'b00;
        mdu_if.i_data_a = 32'hFFFF_FFFD;
        mdu_if.i_data_b = 32'd7;
        mdu_if.i_hilo_read = 1'b1;
        sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
        c = 0;
        while (1) begin
            @(negedge clk);
            c++;
            if (mdu_if.o_done === 1'b1 || c >= 60) break;
            checks++;
            if (mdu_if.o_stall !== 1'b1) begin
                failures++;
                $display("FAIL stall_run c=%0d: got %b expected 1", c, mdu_if.o_stall);
            end
        end
        checks++;
        if (c != 33) begin
            failures++;
            $display("FAIL stall_latency: got %0d expected 33", c);
        end
        checks++;
        if (mdu_if.o_stall !== 1'b0) begin
            failures++;
            $display("FAIL stall_done_cycle: got %b expected 0", mdu_if.o_stall);
        end
        exp = sb_q.pop_front();
        got = {mdu_if.o_hi, mdu_if.o_lo};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_first: got %h expected %h", got, exp);
        end
        @(negedge clk);
        mdu_if.i_start = 1'b0;
        mdu_if.i_hilo_read = 1'b0;
        checks++;
        if (mdu_if.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: got %b expected 1", mdu_if.o_busy);
        end
        wait_done(cyc, to);
        checks++;
        if (to || cyc != 33) begin
            failures++;
            $display("FAIL b2b_latency: got %0d expected 33 (timeout=%0b)", cyc, to);
        end
        exp = sb_q.pop_front();
        got = {mdu_if.o_hi, mdu_if.o_lo};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_second: got %h expected %h", got, exp);
        end
        last_hilo = exp;
    endtask

    task automatic test_flush();
        bit saw_done = 1'b0;
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 1'b0);
        repeat (10) @(negedge clk);
        mdu_if.i_flush = 1'b1;
        @(negedge clk);
        mdu_if.i_flush = 1'b0;
        checks++;
        if (mdu_if.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: got %b expected 0", mdu_if.o_busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (mdu_if.o_done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done || mdu_if.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_done: got done=%b busy=%b expected 0 0", saw_done,
                     mdu_if.o_busy);
        end
        checks++;
        if ({mdu_if.o_hi, mdu_if.o_lo} !== last_hilo) begin
            failures++;
            $display("FAIL flush_hilo: got %h expected %h", {mdu_if.o_hi, mdu_if.o_lo},
                     last_hilo);
        end
        mdu_if.i_start = 1'b1;
        mdu_if.i_flush = 1'b1;
        @(negedge clk);
        mdu_if.i_start = 1'b0;
        mdu_if.i_flush = 1'b0;
        checks++;
        if (mdu_if.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_idle: got %b expected 0", mdu_if.o_busy);
        end
    endtask

    task automatic test_reset_mid();
        issue(2'b11, 32'd1000, 32'd3, 64'h0, 1'b0);
        repeat (10) @(negedge clk);
        mdu_if.i_hilo_read = 1'b1;
        #1;
        checks++;
        if (mdu_if.o_stall !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre_stall: got %b expected 1", mdu_if.o_stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mdu_if.o_busy, mdu_if.o_done, mdu_if.o_stall} !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_ctrl: got %b expected 000",
                     {mdu_if.o_busy, mdu_if.o_done, mdu_if.o_stall});
        end
        checks++;
        if ({mdu_if.o_hi, mdu_if.o_lo} !== 64'h0) begin
            failures++;
            $display("FAIL rstmid_hilo: got %h expected 0", {mdu_if.o_hi, mdu_if.o_lo});
        end
        @(negedge clk);
        mdu_if.i_hilo_read = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_mult_timing();
        test_ops();
        test_stall_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit beside the EX-stage ALU. It executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, one bit per cycle. It raises a stall to the hazard logic while a dependent instruction waits. It is driven by the EX-stage decode and read by MFHI/MFLO through o_hi and o_lo.

Parameters:
NB_DATA, 32, operand and HI/LO width
NB_OP, 2, operation select width
NB_CNT, 6, iteration counter width; must hold NB_DATA

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  EX holds a mul/div instruction
i_op  in  NB_OP  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
i_data_a  in  NB_DATA  rs operand (multiplicand or dividend)
i_data_b  in  NB_DATA  rt operand (multiplier or divisor)
i_hilo_read  in  1  EX holds MFHI or MFLO
i_flush  in  1  abort the in-flight operation
o_busy  out  1  operation in flight
o_stall  out  1  freeze PC, IF/ID and ID/EX
o_done  out  1  one-cycle pulse when HI/LO are updated
o_hi  out  NB_DATA  HI register
o_lo  out  NB_DATA  LO register

Behaviour:
- Reset (async, i_reset=0): state IDLE; o_hi=0, o_lo=0; o_busy=0, o_done=0, counter=0, internal working registers=0.
- States:
  - IDLE: an edge with i_start=1 and i_flush=0 is the accept edge. It latches the op, latches |a| and |b| (signed ops) or a and b (unsigned), latches the result signs, clears the counter, and goes to RUN.
  - RUN: one iteration per edge, NB_DATA edges in total, then goes to FIX.
    - Multiply: radix-2 shift-add into a 2*NB_DATA product.
    - Divide: restoring division.
  - FIX: applies sign correction, writes HI/LO, goes to IDLE. o_done=1 for exactly the following cycle.
- Latency: accept edge at cycle 0; HI/LO written at edge NB_DATA+1; o_done high in cycle NB_DATA+1.
- o_busy = state != IDLE.
- o_stall = o_busy & (i_start | i_hilo_read). It is combinational and drops the same cycle HI/LO become valid.
- i_start while busy is not queued; the stall holds the instruction in EX until IDLE, then it is accepted.
- Back-to-back: i_start in the o_done cycle is accepted at once.
- Results:
  - Multiply: {HI,LO} = product. Signed ops negate the product when the operand signs differ.
  - Divide: LO = quotient, HI = remainder.
  - Signed divide: quotient is negated when the signs differ; the remainder takes the sign of the dividend.
- Divide by zero (b=0): LO = all ones, HI = a. No exception; normal latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- i_flush in RUN or FIX: IDLE at the next edge. HI/LO are unchanged and no o_done pulse is issued.
- i_flush together with i_start in IDLE: not accepted.
- Reset mid-operation: immediate IDLE and HI/LO are cleared.
- o_hi and o_lo always show the committed registers, never partial results.

Optional Feature:
Macro MULDIV_MTHILO_EN.
- Defined: adds ports i_hi_we (in, 1), i_lo_we (in, 1) and i_wdata (in, NB_DATA) for MTHI/MTLO.
  - In IDLE, a write takes effect at the next edge.
  - In IDLE, a write on the same edge as an accepted start also takes effect at that edge; the later FIX result overwrites it.
  - While busy, a write raises o_stall (o_stall also ORs in i_hi_we|i_lo_we) until IDLE and is not applied.
- Undefined: these ports and their logic are absent; HI/LO are written only by FIX and reset.

Test Plan:
- MULT a=0xFFFFFFFD, b=7 -> o_done in cycle 33 after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_busy high for cycles 1-32.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIVU 100/7 -> LO=14, HI=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5 at normal latency.
- During RUN, i_hilo_read=1 -> o_stall=1 every cycle until the o_done cycle, 0 in it. A second i_start held meanwhile is accepted in the o_done cycle and its result is correct.
- i_flush at RUN iteration 10 -> IDLE next edge, HI/LO keep the prior values, no o_done. Separately, i_reset low mid-RUN -> all outputs 0 immediately.
